// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter that shares one combinational ALU between
//               two requesters, with registered operands and result.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [5:0]       req0_a,
  input  logic [5:0]       req0_b,
  input  logic [2:0]       req0_fxn,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [5:0]       req1_a,
  input  logic [5:0]       req1_b,
  input  logic [2:0]       req1_fxn,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [5:0]       rsp_data,
  output logic [5:0]       alu_a,
  output logic [5:0]       alu_b,
  output logic [2:0]       alu_fxn,
  input  logic [5:0]       alu_out,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_one = 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic             r_winner;
  logic [5:0]       r_a;
  logic [5:0]       r_b;
  logic [2:0]       r_fxn;
  logic [5:0]       r_rsp_data;
  logic [CNT_W-1:0] r_op_count;
  logic             w_win;
  logic             w_grant;
  logic             w_rsp_ready;

  always_comb begin
    w_win       = req1_valid;
    w_grant     = 1'b0;
    w_rsp_ready = r_winner ? rsp1_ready : rsp0_ready;
    w_state_nxt = r_state;
    // Under contention the requester that was not served last goes next.
    if (req0_valid && req1_valid) begin
      w_win = ~r_last_grant;
    end
    // Gating with rst keeps the ready outputs low for the whole reset window.
    w_grant = (r_state == S_IDLE) && (req0_valid || req1_valid) && !rst;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (w_rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_winner     <= 1'b0;
      r_a          <= 6'd0;
      r_b          <= 6'd0;
      r_fxn        <= 3'b000;
      r_rsp_data   <= 6'd0;
      r_op_count   <= '0;
    end else begin
      if (w_grant) begin
        r_winner     <= w_win;
        r_last_grant <= w_win;
        r_a          <= w_win ? req1_a   : req0_a;
        r_b          <= w_win ? req1_b   : req0_b;
        r_fxn        <= w_win ? req1_fxn : req0_fxn;
      end
      if (r_state == S_EXEC) begin
        r_rsp_data <= alu_out;
      end
      if ((r_state == S_RESP) && w_rsp_ready) begin
        r_op_count <= r_op_count + c_one;
      end
    end
  end

  assign req0_ready = w_grant && !w_win;
  assign req1_ready = w_grant && w_win;
  assign rsp0_valid = (r_state == S_RESP) && !r_winner;
  assign rsp1_valid = (r_state == S_RESP) && r_winner;
  assign rsp_data   = r_rsp_data;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_fxn    = r_fxn;
  assign busy       = (r_state != S_IDLE);
  assign op_count   = r_op_count;

endmodule
`default_nettype wire
